// File: rtl/float_pkg.sv
// Shared constants and state encoding for the sequential float divider.
// Field widths follow IEEE-754 single precision.
package float_pkg;
   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int QBITS    = 26;

   localparam logic [30:0] INF_MAG  = {8'hFF, 23'h0};
   localparam logic [30:0] ZERO_MAG = 31'h0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIVIDE,
      S_NORMALIZE,
      S_ROUND,
      S_FINISH
   } state_t;
endpackage

// File: rtl/fdiv_mant_core.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// load initialises rem/Q/cnt; last flags the step that produces the final bit.
module fdiv_mant_core
   import float_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [MANT_W:0]   n,
   input  logic [MANT_W:0]   d,
   output logic [QBITS-1:0]  q,
   output logic              last
);
   logic [MANT_W+1:0] rem;
   logic [MANT_W:0]   den;
   logic [4:0]        cnt;
   logic [MANT_W+2:0] diff;

   // rem stays below 2*den, so a one-bit-wider subtract exposes the borrow cleanly
   assign diff = {1'b0, rem} - {2'b00, den};
   assign last = (cnt == 5'(QBITS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         den <= '0;
         cnt <= '0;
         q   <= '0;
      end else if (load) begin
         rem <= {1'b0, n};
         den <= d;
         cnt <= '0;
         q   <= '0;
      end else if (step) begin
         if (!diff[MANT_W+2]) begin
            rem <= {diff[MANT_W:0], 1'b0};
            q   <= {q[QBITS-2:0], 1'b1};
         end else begin
            rem <= {rem[MANT_W:0], 1'b0};
            q   <= {q[QBITS-2:0], 1'b0};
         end
         cnt <= cnt + 5'd1;
      end
   end
endmodule

// File: rtl/float_div.sv
// Sequential single-precision divider, result 29 cycles after the accepting edge.
// FLOAT_DIV_SPECIAL_EN enables zero-field and exponent range special-casing.
module float_div
   import float_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] float_in_1,
   input  logic [31:0] float_in_2,
   output logic [31:0] float_out,
   output logic        ready,
   output logic        busy
);
   state_t state, state_n;

   logic              core_load;
   logic              core_step;
   logic              core_last;
   logic [QBITS-1:0]  q;

   logic              sign;
   logic signed [9:0] exp_r;
   logic [MANT_W-1:0] mant;
   logic              guard;
   logic [MANT_W:0]   rsum;
   logic [EXP_W-1:0]  exp_field;
   logic [31:0]       result;

   fdiv_mant_core u_core (
      .clk  (clk),
      .rst  (rst),
      .load (core_load),
      .step (core_step),
      .n    ({1'b1, float_in_1[MANT_W-1:0]}),
      .d    ({1'b1, float_in_2[MANT_W-1:0]}),
      .q    (q),
      .last (core_last)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               core_load = 1'b1;
               state_n   = S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            core_step = 1'b1;
            if (core_last) state_n = S_NORMALIZE;
         end
         S_NORMALIZE: state_n = S_ROUND;
         S_ROUND:     state_n = S_FINISH;
         S_FINISH:    state_n = S_IDLE;
         default:     state_n = S_IDLE;
      endcase
   end

   assign rsum      = {1'b0, mant} + {{MANT_W{1'b0}}, guard};
   assign exp_field = 8'(exp_r + 10'(EXP_BIAS));

`ifdef FLOAT_DIV_SPECIAL_EN
   logic              spec_flag;
   logic [30:0]       spec_mag;
   logic signed [9:0] biased;

   assign biased = exp_r + 10'sd127;

   always_comb begin
      result = {sign, exp_field, mant};
      if (spec_flag)                 result = {sign, spec_mag};
      else if (biased > 10'sd254)    result = {sign, INF_MAG};
      else if (biased < 10'sd1)      result = {sign, ZERO_MAG};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_flag <= 1'b0;
         spec_mag  <= '0;
      end else if (state == S_IDLE && start) begin
         // a zero divisor wins over a zero dividend, so 0/0 yields infinity
         spec_flag <= (float_in_2[30:23] == 8'h00) || (float_in_1[30:23] == 8'h00);
         spec_mag  <= (float_in_2[30:23] == 8'h00) ? INF_MAG : ZERO_MAG;
      end
   end
`else
   always_comb begin
      result = {sign, exp_field, mant};
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         float_out <= '0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         sign      <= 1'b0;
         exp_r     <= '0;
         mant      <= '0;
         guard     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               ready <= 1'b0;
               if (start) begin
                  sign  <= float_in_1[31] ^ float_in_2[31];
                  exp_r <= $signed({2'b00, float_in_1[30:23]} - {2'b00, float_in_2[30:23]});
                  busy  <= 1'b1;
               end
            end
            S_NORMALIZE: begin
               // ratio in (0.5,2): either the integer bit is set or the next one is
               if (q[QBITS-1]) begin
                  mant  <= q[QBITS-2:2];
                  guard <= q[1];
               end else begin
                  mant  <= q[QBITS-3:1];
                  guard <= q[0];
                  exp_r <= exp_r - 10'sd1;
               end
            end
            S_ROUND: begin
               mant  <= rsum[MANT_W-1:0];
               exp_r <= exp_r + $signed({9'd0, rsum[MANT_W]});
            end
            S_FINISH: begin
               float_out <= result;
               ready     <= 1'b1;
               busy      <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_float_div.sv
// Directed and random checks of float_div against an integer-arithmetic quotient model.
// Covers latency, handshake, busy-start rejection, mid-op reset and back-to-back issue.
module tb_float_div;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] float_in_1;
   logic [31:0] float_in_2;
   logic [31:0] float_out;
   logic        ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   float_div dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .float_in_1 (float_in_1),
      .float_in_2 (float_in_2),
      .float_out  (float_out),
      .ready      (ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      longint n, d, q, m, g, e;
      logic s;
      logic [31:0] eb;
      s = a[31] ^ b[31];
      n = longint'({1'b1, a[22:0]});
      d = longint'({1'b1, b[22:0]});
      q = (n <<< 25) / d;                 // 26-bit truncated quotient, integer bit at 2^25
      e = longint'(a[30:23]) - longint'(b[30:23]);
      if (q >= (longint'(1) <<< 25)) begin
         m = (q >>> 2) & 64'h7FFFFF;
         g = (q >>> 1) & 1;
      end else begin
         m = (q >>> 1) & 64'h7FFFFF;
         g = q & 1;
         e = e - 1;
      end
      m = m + g;
      if (m >= 64'h800000) begin
         m = 0;
         e = e + 1;
      end
      eb = 32'(e + 127);
`ifdef FLOAT_DIV_SPECIAL_EN
      if (b[30:23] == 8'h00) return {s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00) return {s, 31'h0};
      if (e + 127 > 254)     return {s, 8'hFF, 23'h0};
      if (e + 127 < 1)       return {s, 31'h0};
`endif
      return {s, eb[7:0], m[22:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // waits for ready after an accepting edge; returns cycles counted
   task automatic wait_ready(output int lat);
      lat = 0;
      while (!ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic count_ready(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (ready) seen++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
      int lat;
      logic [31:0] expv;
      expv = ref_div(a, b);
      @(negedge clk);
      float_in_1 = a;
      float_in_2 = b;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      float_in_1 = $urandom;
      float_in_2 = $urandom;
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_ready(lat);
      check({tag, "_lat"}, 32'(lat), 32'd29);
      check({tag, "_out"}, float_out, expv);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_ready_width"}, {31'd0, ready}, 32'd0);
   endtask

   initial begin
      int lat;
      int seen;
      logic [31:0] ra, rb;

      rst = 1'b1; start = 1'b0; float_in_1 = '0; float_in_2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", float_out, 32'h0);
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); rst = 1'b0;

      run_op(32'h40C00000, 32'h40000000, "six_by_two");
      check("six_by_two_const", float_out, 32'h40400000);
      run_op(32'h3F800000, 32'h40400000, "one_third");
      check("one_third_const", float_out, 32'h3EAAAAAB);
      run_op(32'hBF800000, 32'h40800000, "neg_quarter");
      check("neg_quarter_const", float_out, 32'hBE800000);

      // start pulse while busy must be ignored
      @(negedge clk);
      float_in_1 = 32'h40C00000; float_in_2 = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      float_in_1 = 32'h3F800000; float_in_2 = 32'h40400000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      lat = 6;
      while (!ready && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("busy_start_lat", 32'(lat), 32'd29);
      check("busy_start_out", float_out, 32'h40400000);
      count_ready(40, seen);
      check("busy_start_no_extra", 32'(seen), 32'd0);

      // reset in the middle of an operation
      @(negedge clk);
      float_in_1 = 32'h40C00000; float_in_2 = 32'h40000000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out", float_out, 32'h0);
      check("midrst_ready", {31'd0, ready}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); rst = 1'b0;
      count_ready(40, seen);
      check("midrst_no_ready", 32'(seen), 32'd0);
      run_op(32'h41200000, 32'h40A00000, "ten_by_five");
      check("ten_by_five_const", float_out, 32'h40000000);

      // start held high: next op accepted on the edge that clears ready
      @(negedge clk);
      float_in_1 = 32'h3F800000; float_in_2 = 32'h40400000; start = 1'b1;
      @(posedge clk); #1;
      wait_ready(lat);
      check("b2b_lat1", 32'(lat), 32'd29);
      check("b2b_out1", float_out, 32'h3EAAAAAB);
      float_in_1 = 32'h41200000; float_in_2 = 32'h40A00000;
      @(posedge clk); #1;
      check("b2b_ready_clear", {31'd0, ready}, 32'd0);
      check("b2b_busy_again", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_ready(lat);
      check("b2b_lat2", 32'(lat), 32'd29);
      check("b2b_out2", float_out, 32'h40000000);
      @(posedge clk); #1;

`ifdef FLOAT_DIV_SPECIAL_EN
      run_op(32'h3F800000, 32'h00000000, "div_by_zero");
      check("div_by_zero_const", float_out, 32'h7F800000);
      run_op(32'h00000000, 32'h40000000, "zero_dividend");
      check("zero_dividend_const", float_out, 32'h00000000);
`endif

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
